line_word_sel: RTL and testbench
================================

# line_word_sel

Registered, parametrised word selector and line serializer for the direct-mapped data cache. It captures one cache line of WORDS words and returns either the single addressed word or the whole line in critical-word-first wrap order. Output uses a valid/ready handshake. It sits between the cache data array / refill path and the CPU-side read port. It replaces fixed-width, fixed-count combinational word muxing.

## Interface
Parameters:
- WIDTH, 32, bits per word (≥1)
- WORDS, 4, words per line; power of two, ≥2
- OFF_W (localparam), $clog2(WORDS), word-offset width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- line_valid  in  1  line_data/start_off/mode are valid
- line_ready  out  1  block can accept a line
- line_data  in  WIDTH*WORDS  word i at bits [i*WIDTH +: WIDTH]
- start_off  in  OFF_W  first (critical) word offset
- mode  in  1  0 = single word, 1 = full-line burst
- out_valid  out  1  out_data/out_off/out_last valid
- out_ready  in  1  consumer accepts the current word
- out_data  out  WIDTH  selected word
- out_off  out  OFF_W  offset of out_data within the line
- out_last  out  1  current word is the final word of the transfer
- busy  out  1  a transfer is in progress

## Operation
- The FSM has two states: IDLE and SEND.
- **IDLE:**
  - line_ready=1, out_valid=0, busy=0.
  - On line_valid&&line_ready, register line_data into the line buffer.
  - Set ptr=start_off and cnt=0, latch mode, then go to SEND.
- **SEND:**
  - line_ready=0, busy=1, out_valid=1.
  - out_data=buf[ptr], out_off=ptr.
  - out_last = (mode==0) || (cnt==WORDS-1).
- **Handshake:** a word transfers on the edge where out_valid&&out_ready.
  - If out_last, go to IDLE.
  - Otherwise ptr=ptr+1 mod WORDS (wrap-around, OFF_W-bit natural overflow) and cnt=cnt+1.
- While out_valid&&!out_ready, out_data, out_off and out_last hold stable. There is no drop and no advance.
- **Burst order:** start_off, start_off+1, …, wrapping to 0, ending at start_off-1. Exactly WORDS words are sent, each offset exactly once.
- **Single mode:** exactly one word is sent, buf[start_off], with out_last=1.
- line_valid is ignored while busy. The input side must hold line_valid until line_ready. Inputs not accepted have no effect.
- out_data/out_off/out_last depend only on registers. There is no combinational path from any input to any output.
- **Reset (async, any state including mid-burst):**
  - State=IDLE, buffer cleared to 0, ptr=0, cnt=0; the in-flight transfer is abandoned.
  - Outputs during and after reset: line_ready=1, out_valid=0, out_data=0, out_off=0, out_last=0, busy=0.

## Timing
- **Accept-to-output latency:** 1 cycle. The line is accepted at edge N; out_valid=1 with the first word after edge N.
- **Burst throughput:** 1 word/cycle with out_ready held high. A full burst occupies WORDS cycles in SEND.
- **Turnaround:** after the last handshake at edge M, the block is in IDLE with line_ready=1 after M. The next line is accepted at earliest at edge M+1.
  - This gives 1 bubble cycle between transfers; minimum period per line is WORDS+1 cycles (burst) or 2 cycles (single).
- **Simultaneous events:**
  - line_valid arriving in the same cycle as the final handshake is not accepted. line_ready is 0 in SEND.
  - rst overrides every other input in every cycle.
- **Out-of-range values:** none possible. start_off is OFF_W bits and WORDS is a power of two.

## Test plan
- **Reset:**
  - Assert rst mid-burst after 2 of 4 words; require out_valid=0, out_data=0, busy=0 and line_ready=1 immediately, without waiting for clk.
  - After release, a new line is accepted normally.
- **Single mode:** WIDTH=32, WORDS=4, line words {0x0,0x64,0xC8,0x12C}, start_off=2, mode=0.
  - Expect one beat: out_data=0xC8, out_off=2, out_last=1, one cycle after accept.
  - Return to IDLE after the handshake.
- **Wrapped burst:** same line, start_off=3, mode=1, out_ready=1.
  - Expect out_off 3,0,1,2 with out_data 0x12C,0x0,0x64,0xC8 on 4 consecutive cycles.
  - out_last=1 only on the 4th beat.
- **Backpressure:** burst from start_off=0 with out_ready toggled 1,0,0,1,1,0,1.
  - Outputs hold stable on every stalled cycle.
  - Sequence 0x0,0x64,0xC8,0x12C is delivered with no loss or duplicate.
- **Busy/ignore:** pulse line_valid with a different line during SEND.
  - The current burst is unaffected; the second line is accepted only after the 1-cycle IDLE bubble.
- **Parametrisation:** WIDTH=8, WORDS=8, start_off=5, burst with random out_ready.
  - Expect offsets 5,6,7,0,1,2,3,4 with correct bytes; out_last only on offset 4.

Source files
------------

// File: rtl/line_word_sel.sv
// line_word_sel: registers one cache line and streams the addressed word or the
// whole line in critical-word-first wrap order over a valid/ready port.
module line_word_sel #(
    parameter int WIDTH = 32,
    parameter int WORDS = 4,
    localparam int OFF_W = $clog2(WORDS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   line_valid,
    output logic                   line_ready,
    input  logic [WIDTH*WORDS-1:0] line_data,
    input  logic [OFF_W-1:0]       start_off,
    input  logic                   mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [OFF_W-1:0]       out_off,
    output logic                   out_last,
    output logic                   busy
);
    localparam logic S_IDLE = 1'b0;
    localparam logic S_SEND = 1'b1;

    logic                         state_q, state_d;
    logic [WORDS-1:0][WIDTH-1:0]  line_q, line_d;
    logic [OFF_W-1:0]             ptr_q, ptr_d, cnt_q, cnt_d;
    logic                         mode_q, mode_d;
    logic                         send, last, accept, adv;

    assign send   = state_q == S_SEND;
    assign last   = !mode_q || cnt_q == OFF_W'(WORDS - 1);
    assign accept = !send && line_valid;
    assign adv    = send && out_ready && !last;

    always_comb begin
        line_d  = accept ? line_data : line_q;
        mode_d  = accept ? mode : mode_q;
        ptr_d   = accept ? start_off : adv ? ptr_q + 1'b1 : ptr_q;
        cnt_d   = accept ? '0 : adv ? cnt_q + 1'b1 : cnt_q;
        state_d = accept ? S_SEND : (send && out_ready && last) ? S_IDLE : state_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            line_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    // All outputs come straight from registers; data/last are gated so IDLE shows zeros.
    assign line_ready = !send;
    assign out_valid  = send;
    assign busy       = send;
    assign out_data   = send ? line_q[ptr_q] : '0;
    assign out_off    = ptr_q;
    assign out_last   = send && last;
endmodule

// File: tb/tb_line_word_sel.sv
// tb_line_word_sel: randomized and directed checks of line_word_sel against a
// sequence model (offset k of a transfer = (start + k) mod WORDS).
module tb_line_word_sel;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         line_valid0, line_ready0, mode0, out_valid0, out_ready0, out_last0, busy0;
    logic [127:0] line_data0;
    logic [1:0]   start_off0, out_off0;
    logic [31:0]  out_data0;

    logic         line_valid1, line_ready1, mode1, out_valid1, out_ready1, out_last1, busy1;
    logic [63:0]  line_data1;
    logic [2:0]   start_off1, out_off1;
    logic [7:0]   out_data1;

    int tests = 0;
    int fails = 0;
    logic [31:0] w0 [4];
    logic [31:0] w1 [4];
    logic [127:0] l0, l1;

    line_word_sel #(.WIDTH(32), .WORDS(4)) d0 (
        .clk(clk), .rst(rst), .line_valid(line_valid0), .line_ready(line_ready0),
        .line_data(line_data0), .start_off(start_off0), .mode(mode0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
        .out_off(out_off0), .out_last(out_last0), .busy(busy0)
    );

    line_word_sel #(.WIDTH(8), .WORDS(8)) d1 (
        .clk(clk), .rst(rst), .line_valid(line_valid1), .line_ready(line_ready1),
        .line_data(line_data1), .start_off(start_off1), .mode(mode1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .out_off(out_off1), .out_last(out_last1), .busy(busy1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept0(input logic [127:0] l, input int s, input logic m);
        line_data0  = l;
        start_off0  = s[1:0];
        mode0       = m;
        line_valid0 = 1'b1;
        step();
        line_valid0 = 1'b0;
    endtask

    task automatic test_reset();
        tests++;
        if ({line_ready0, out_valid0, out_data0, out_off0, out_last0, busy0} !== {1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_state got rdy=%b v=%b d=%h off=%0d last=%b busy=%b exp rdy=1 v=0 d=0 off=0 last=0 busy=0",
                     line_ready0, out_valid0, out_data0, out_off0, out_last0, busy0);
        end
        tests++;
        if ({line_ready1, out_valid1, out_data1, busy1} !== {1'b1, 1'b0, 8'h0, 1'b0}) begin
            fails++;
            $display("FAIL reset_state_p8 got rdy=%b v=%b d=%h busy=%b exp 1 0 00 0", line_ready1, out_valid1, out_data1, busy1);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        out_ready0 = 1'b0;
        accept0(l0, 2, 1'b0);
        for (int c = 0; c < 2; c++) begin
            tests++;
            if ({out_valid0, out_off0, out_last0, out_data0, busy0, line_ready0} !== {1'b1, 2'd2, 1'b1, w0[2], 1'b1, 1'b0}) begin
                fails++;
                $display("FAIL single_beat%0d got v=%b off=%0d last=%b d=%h busy=%b rdy=%b exp v=1 off=2 last=1 d=%h busy=1 rdy=0",
                         c, out_valid0, out_off0, out_last0, out_data0, busy0, line_ready0, w0[2]);
            end
            if (c == 0) step();
        end
        out_ready0 = 1'b1;
        step();
        out_ready0 = 1'b0;
        tests++;
        if ({out_valid0, busy0, line_ready0} !== 3'b001) begin
            fails++;
            $display("FAIL single_idle got v=%b busy=%b rdy=%b exp 0 0 1", out_valid0, busy0, line_ready0);
        end
    endtask

    task automatic test_wrapped_burst();
        int off;
        out_ready0 = 1'b1;
        accept0(l0, 3, 1'b1);
        for (int k = 0; k < 4; k++) begin
            off = (3 + k) % 4;
            tests++;
            if ({out_valid0, out_off0, out_last0, out_data0} !== {1'b1, off[1:0], k == 3, w0[off]}) begin
                fails++;
                $display("FAIL wrap_beat%0d got v=%b off=%0d last=%b d=%h exp v=1 off=%0d last=%b d=%h",
                         k, out_valid0, out_off0, out_last0, out_data0, off, k == 3, w0[off]);
            end
            step();
        end
        out_ready0 = 1'b0;
        tests++;
        if (out_valid0 !== 1'b0) begin
            fails++;
            $display("FAIL wrap_end got v=%b exp 0", out_valid0);
        end
    endtask

    task automatic test_backpressure();
        logic pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic r;
        int k = 0;
        int cyc = 0;
        accept0(l0, 0, 1'b1);
        while (k < 4 && cyc < 40) begin
            tests++;
            if ({out_valid0, out_off0, out_last0, out_data0} !== {1'b1, k[1:0], k == 3, w0[k]}) begin
                fails++;
                $display("FAIL bp_cyc%0d got v=%b off=%0d last=%b d=%h exp v=1 off=%0d last=%b d=%h",
                         cyc, out_valid0, out_off0, out_last0, out_data0, k, k == 3, w0[k]);
            end
            r = cyc < 7 ? pat[cyc] : 1'b1;
            out_ready0 = r;
            step();
            if (r) k++;
            cyc++;
        end
        out_ready0 = 1'b0;
        tests++;
        if (k != 4 || out_valid0 !== 1'b0) begin
            fails++;
            $display("FAIL bp_done got beats=%0d v=%b exp beats=4 v=0", k, out_valid0);
        end
    endtask

    task automatic test_busy_ignore();
        int off;
        out_ready0 = 1'b1;
        accept0(l0, 1, 1'b1);
        line_data0  = l1;
        start_off0  = 2'd2;
        mode0       = 1'b0;
        line_valid0 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            off = (1 + k) % 4;
            tests++;
            if ({out_valid0, out_off0, out_last0, out_data0, line_ready0} !== {1'b1, off[1:0], k == 3, w0[off], 1'b0}) begin
                fails++;
                $display("FAIL busy_beat%0d got v=%b off=%0d last=%b d=%h rdy=%b exp v=1 off=%0d last=%b d=%h rdy=0",
                         k, out_valid0, out_off0, out_last0, out_data0, line_ready0, off, k == 3, w0[off]);
            end
            step();
        end
        out_ready0 = 1'b0;
        tests++;
        if ({out_valid0, line_ready0, busy0} !== 3'b010) begin
            fails++;
            $display("FAIL busy_bubble got v=%b rdy=%b busy=%b exp 0 1 0", out_valid0, line_ready0, busy0);
        end
        step();
        line_valid0 = 1'b0;
        tests++;
        if ({out_valid0, out_off0, out_last0, out_data0} !== {1'b1, 2'd2, 1'b1, w1[2]}) begin
            fails++;
            $display("FAIL busy_second got v=%b off=%0d last=%b d=%h exp v=1 off=2 last=1 d=%h",
                     out_valid0, out_off0, out_last0, out_data0, w1[2]);
        end
        out_ready0 = 1'b1;
        step();
        out_ready0 = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        out_ready0 = 1'b1;
        accept0(l1, 0, 1'b1);
        step();
        step();
        rst = 1'b1;
        #1;
        tests++;
        if ({out_valid0, out_data0, busy0, line_ready0, out_off0, out_last0} !== {1'b0, 32'h0, 1'b0, 1'b1, 2'd0, 1'b0}) begin
            fails++;
            $display("FAIL reset_mid got v=%b d=%h busy=%b rdy=%b off=%0d last=%b exp v=0 d=0 busy=0 rdy=1 off=0 last=0",
                     out_valid0, out_data0, busy0, line_ready0, out_off0, out_last0);
        end
        #2;
        rst = 1'b0;
        step();
        out_ready0 = 1'b0;
        accept0(l0, 3, 1'b0);
        tests++;
        if ({out_valid0, out_off0, out_last0, out_data0} !== {1'b1, 2'd3, 1'b1, w0[3]}) begin
            fails++;
            $display("FAIL reset_after got v=%b off=%0d last=%b d=%h exp v=1 off=3 last=1 d=%h",
                     out_valid0, out_off0, out_last0, out_data0, w0[3]);
        end
        out_ready0 = 1'b1;
        step();
        out_ready0 = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] w [4];
        logic [127:0] l;
        logic m, r;
        int s, off, n, k, cyc;
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 4; i++) begin
                w[i] = $urandom;
                l[i*32 +: 32] = w[i];
            end
            s = $urandom_range(0, 3);
            m = 1'(t % 3 != 0);
            n = m ? 4 : 1;
            accept0(l, s, m);
            k = 0;
            cyc = 0;
            while (k < n && cyc < 60) begin
                off = (s + k) % 4;
                tests++;
                if ({out_valid0, out_off0, out_last0, out_data0} !== {1'b1, off[1:0], k == n - 1, w[off]}) begin
                    fails++;
                    $display("FAIL rand%0d_k%0d got v=%b off=%0d last=%b d=%h exp v=1 off=%0d last=%b d=%h",
                             t, k, out_valid0, out_off0, out_last0, out_data0, off, k == n - 1, w[off]);
                end
                r = 1'($urandom_range(0, 1));
                out_ready0 = r;
                step();
                if (r) k++;
                cyc++;
            end
            out_ready0 = 1'b0;
            tests++;
            if (k != n || out_valid0 !== 1'b0) begin
                fails++;
                $display("FAIL rand%0d_done got beats=%0d v=%b exp beats=%0d v=0", t, k, out_valid0, n);
            end
        end
    endtask

    task automatic test_param();
        logic [7:0] b [8];
        logic r;
        int off;
        int k = 0;
        int cyc = 0;
        for (int i = 0; i < 8; i++) begin
            b[i] = 8'($urandom_range(0, 255));
            line_data1[i*8 +: 8] = b[i];
        end
        start_off1  = 3'd5;
        mode1       = 1'b1;
        out_ready1  = 1'b0;
        line_valid1 = 1'b1;
        step();
        line_valid1 = 1'b0;
        while (k < 8 && cyc < 100) begin
            off = (5 + k) % 8;
            tests++;
            if ({out_valid1, out_off1, out_last1, out_data1} !== {1'b1, off[2:0], k == 7, b[off]}) begin
                fails++;
                $display("FAIL p8_k%0d got v=%b off=%0d last=%b d=%h exp v=1 off=%0d last=%b d=%h",
                         k, out_valid1, out_off1, out_last1, out_data1, off, k == 7, b[off]);
            end
            r = 1'($urandom_range(0, 1));
            out_ready1 = r;
            step();
            if (r) k++;
            cyc++;
        end
        out_ready1 = 1'b0;
        tests++;
        if (k != 8 || out_valid1 !== 1'b0) begin
            fails++;
            $display("FAIL p8_done got beats=%0d v=%b exp beats=8 v=0", k, out_valid1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        {line_valid0, mode0, out_ready0, start_off0, line_data0} = '0;
        {line_valid1, mode1, out_ready1, start_off1, line_data1} = '0;
        w0 = '{32'h0, 32'h64, 32'hC8, 32'h12C};
        for (int i = 0; i < 4; i++) begin
            w1[i] = $urandom;
            l0[i*32 +: 32] = w0[i];
            l1[i*32 +: 32] = w1[i];
        end
        #2;
        test_reset();
        test_single();
        test_wrapped_burst();
        test_backpressure();
        test_busy_ignore();
        test_reset_mid_burst();
        test_random();
        test_param();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
